// File: rtl/dac_shift_controller.sv
// dac_shift_controller
// Automatic shift (gain) controller for the TX DAC output stage. It watches the
// signed 28-bit TX sample stream ahead of the DAC corrector and drives the
// corrector's shift so that the top 14 bits of the shifted sample keep as much
// resolution as possible without clipping. A loud sample reduces the shift at
// once (attack). A quiet window raises it by at most one step (release). A
// manual override exists for calibration.
//
// Ports:
//   clk_in          system clock
//   reset_n         synchronous active-low reset
//   DATA_IN[27:0]   signed TX sample, same stream fed to the corrector
//   data_valid      DATA_IN qualifier
//   tx_enable       automatic control enabled while high
//   manual_mode     forces manual_distance onto the output
//   manual_distance host-requested shift, clamped to MAX_SHIFT
//   distance[7:0]   registered shift to the corrector
//   clip_flag       one-cycle pulse on each attack event
//   peak_lz[4:0]    leading-zero count of the last completed window peak
//   state[1:0]      FSM state, for debug (0 IDLE, 1 MEASURE, 2 UPDATE, 3 MANUAL)
module dac_shift_controller #(
   parameter int WIN_LOG2  = 12,
   parameter int MAX_SHIFT = 14,
   parameter int HEADROOM  = 1
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic [27:0] DATA_IN,
   input  logic        data_valid,
   input  logic        tx_enable,
   input  logic        manual_mode,
   input  logic [7:0]  manual_distance,
   output logic [7:0]  distance,
   output logic        clip_flag,
   output logic [4:0]  peak_lz,
   output logic [1:0]  state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_UPDATE  = 2'd2;
   localparam logic [1:0] ST_MANUAL  = 2'd3;
   localparam logic [7:0] MAX_SHIFT_L = 8'(MAX_SHIFT);

   // Leading zeros counted from bit 26; the highest set bit wins, zero gives 27.
   function automatic logic [4:0] count_lz(input logic [26:0] m);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (m[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   // Shift that keeps HEADROOM guard bits free, clamped to 0..MAX_SHIFT.
   function automatic logic [7:0] safe_shift(input logic [4:0] x);
      int v;
      v = int'(x) - HEADROOM;
      if (v < 0) v = 0;
      else if (v > MAX_SHIFT) v = MAX_SHIFT;
      return 8'(v);
   endfunction

   // ---------------- stage 1: magnitude and leading zeros ----------------
   // One's complement for negatives keeps -2^27 representable in 27 bits.
   logic [26:0] mag;
   logic [4:0]  lz;
   assign mag = DATA_IN[27] ? ~DATA_IN[26:0] : DATA_IN[26:0];
   assign lz  = count_lz(mag);

   logic [26:0] s1_mag_q;
   logic [4:0]  s1_lz_q;
   logic        s1_valid_q;

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_mag_q   <= '0;
         s1_lz_q    <= 5'd27;
      end else begin
         s1_valid_q <= data_valid;
         s1_mag_q   <= mag;
         s1_lz_q    <= lz;
      end
   end

   // ---------------- stage 2: control decision ----------------
   logic [1:0]          state_q, state_d;
   logic [7:0]          distance_q, distance_d;
   logic                clip_q, clip_d;
   logic [4:0]          peak_lz_q, peak_lz_d;
   logic [26:0]         peak_q, peak_d;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;

   logic        attack;
   logic [26:0] peak_max;
   logic [4:0]  peak_lz_now;
   logic [7:0]  target;

   assign attack      = s1_valid_q && (int'(s1_lz_q) < int'(distance_q) + HEADROOM);
   assign peak_max    = (s1_mag_q > peak_q) ? s1_mag_q : peak_q;
   assign peak_lz_now = count_lz(peak_q);
   assign target      = safe_shift(peak_lz_now);

   always_comb begin
      state_d    = state_q;
      distance_d = distance_q;
      clip_d     = 1'b0;
      peak_lz_d  = peak_lz_q;
      peak_d     = peak_q;
      cnt_d      = cnt_q;
      if (manual_mode) begin
         // Override: report clipping but leave the shift under host control.
         state_d    = ST_MANUAL;
         distance_d = (manual_distance > MAX_SHIFT_L) ? MAX_SHIFT_L : manual_distance;
         clip_d     = attack;
         peak_d     = '0;
         cnt_d      = '0;
      end else if (state_q == ST_MANUAL || !tx_enable) begin
         state_d = ST_IDLE;
         peak_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_MEASURE;
               peak_d  = '0;
               cnt_d   = '0;
            end
            ST_MEASURE: begin
               if (s1_valid_q) begin
                  peak_d = peak_max;
                  cnt_d  = cnt_q + 1'b1;
                  if (attack) begin
                     distance_d = safe_shift(s1_lz_q);
                     clip_d     = 1'b1;
                  end
                  // Last sample of the window: its magnitude is already in peak_d.
                  if (&cnt_q) state_d = ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               peak_lz_d = peak_lz_now;
               state_d   = ST_MEASURE;
               // A sample arriving now opens the next window.
               peak_d    = s1_valid_q ? s1_mag_q : '0;
               cnt_d     = WIN_LOG2'(s1_valid_q);
               if (attack) begin
                  distance_d = safe_shift(s1_lz_q);
                  clip_d     = 1'b1;
               end else if (target > distance_q) begin
                  distance_d = distance_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         distance_q <= 8'd0;
         clip_q     <= 1'b0;
         peak_lz_q  <= 5'd27;
         peak_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         distance_q <= distance_d;
         clip_q     <= clip_d;
         peak_lz_q  <= peak_lz_d;
         peak_q     <= peak_d;
         cnt_q      <= cnt_d;
      end
   end

   assign distance  = distance_q;
   assign clip_flag = clip_q;
   assign peak_lz   = peak_lz_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dac_shift_controller.sv
// tb_dac_shift_controller
// Directed scenarios followed by randomized traffic. Each cycle the DUT outputs
// are compared against a behavioural model of the shift-control rules.
module tb_dac_shift_controller;

   localparam int WIN_LOG2  = 4;
   localparam int MAX_SHIFT = 14;
   localparam int HEADROOM  = 1;
   localparam int WIN       = 1 << WIN_LOG2;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic [27:0] DATA_IN = '0;
   logic        data_valid = 1'b0;
   logic        tx_enable = 1'b0;
   logic        manual_mode = 1'b0;
   logic [7:0]  manual_distance = '0;
   logic [7:0]  distance;
   logic        clip_flag;
   logic [4:0]  peak_lz;
   logic [1:0]  state;

   dac_shift_controller #(
      .WIN_LOG2 (WIN_LOG2),
      .MAX_SHIFT(MAX_SHIFT),
      .HEADROOM (HEADROOM)
   ) dut (
      .clk_in         (clk_in),
      .reset_n        (reset_n),
      .DATA_IN        (DATA_IN),
      .data_valid     (data_valid),
      .tx_enable      (tx_enable),
      .manual_mode    (manual_mode),
      .manual_distance(manual_distance),
      .distance       (distance),
      .clip_flag      (clip_flag),
      .peak_lz        (peak_lz),
      .state          (state)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   int     m_dist, m_clip, m_plz, m_state, m_cnt;
   longint m_peak;
   bit     p_valid;     // sample waiting for its decision (one-cycle pipeline)
   longint p_mag;
   int     p_lz;

   function automatic longint mag_of(input logic [27:0] d);
      longint s;
      s = longint'($signed(d));
      return (s < 0) ? (-s - 1) : s;
   endfunction

   function automatic int lz_of(input longint m);
      int b;
      b = 0;
      while (b < 27 && ((m >> b) != 0)) b++;
      return 27 - b;
   endfunction

   function automatic int safe_of(input int x);
      int v;
      v = x - HEADROOM;
      if (v < 0) v = 0;
      if (v > MAX_SHIFT) v = MAX_SHIFT;
      return v;
   endfunction

   task automatic model_step(input bit rst_n, input logic [27:0] d, input bit v,
                             input bit te, input bit mm, input int md);
      bit attack;
      int tgt;
      if (!rst_n) begin
         m_dist = 0; m_clip = 0; m_plz = 27; m_state = 0; m_cnt = 0; m_peak = 0;
         p_valid = 0; p_mag = 0; p_lz = 27;
         return;
      end
      m_clip = 0;
      attack = p_valid && (p_lz < m_dist + HEADROOM);
      if (mm) begin
         m_state = 3;
         m_dist  = (md > MAX_SHIFT) ? MAX_SHIFT : md;
         m_clip  = attack ? 1 : 0;
         m_cnt   = 0;
         m_peak  = 0;
      end else if (m_state == 3 || !te) begin
         m_state = 0;
         m_cnt   = 0;
         m_peak  = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (p_valid) begin
            if (p_mag > m_peak) m_peak = p_mag;
            m_cnt++;
            if (attack) begin
               m_dist = safe_of(p_lz);
               m_clip = 1;
            end
            if (m_cnt == WIN) begin
               m_state = 2;
               m_cnt   = 0;
            end
         end
      end else begin
         m_plz = lz_of(m_peak);
         tgt   = safe_of(m_plz);
         if (attack) begin
            m_dist = safe_of(p_lz);
            m_clip = 1;
         end else if (tgt > m_dist) begin
            m_dist++;
         end
         m_peak  = p_valid ? p_mag : 0;
         m_cnt   = p_valid ? 1 : 0;
         m_state = 1;
      end
      p_valid = v;
      p_mag   = mag_of(d);
      p_lz    = lz_of(p_mag);
   endtask

   // One clock: drive inputs, advance the model with the same edge, compare.
   task automatic cycle(input bit rst_n, input logic [27:0] d, input bit v,
                        input bit te, input bit mm, input logic [7:0] md);
      reset_n = rst_n; DATA_IN = d; data_valid = v;
      tx_enable = te; manual_mode = mm; manual_distance = md;
      @(posedge clk_in);
      model_step(rst_n, d, v, te, mm, int'(md));
      #1;
      check_value("distance", int'(distance), m_dist);
      check_value("clip_flag", int'(clip_flag), m_clip);
      check_value("peak_lz", int'(peak_lz), m_plz);
      check_value("state", int'(state), m_state);
      check_value("dist_bound", int'(distance <= 8'(MAX_SHIFT)), 1);
   endtask

   localparam logic [27:0] QUIET = 28'h0000100;

   initial begin
      bit          r_rst, r_te, r_mm, r_v, synced;
      logic [7:0]  r_md;
      logic signed [27:0] r_d;

      // Reset state
      for (int i = 0; i < 3; i++) cycle(1'b0, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("reset_distance", int'(distance), 0);
      check_value("reset_peak_lz", int'(peak_lz), 27);
      check_value("reset_state", int'(state), 0);

      // Slow release up to the clamp
      for (int i = 0; i < 16 * WIN + 8; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("ramp_final", int'(distance), 14);
      check_value("ramp_peak_lz", int'(peak_lz), 18);

      // Fast attack from 14 with lz=6
      cycle(1'b1, 28'h0100000, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("attack6_dist", int'(distance), 5);
      check_value("attack6_clip", int'(clip_flag), 1);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("attack6_clip_off", int'(clip_flag), 0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 28'h0100000, 1'b1, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 2; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("attack6_repeat", int'(distance), 5);

      // Back to 14, then a negative loud sample and full scale
      for (int i = 0; i < 12 * WIN; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("reramp", int'(distance), 14);
      cycle(1'b1, 28'hFF00000, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("attack_neg_dist", int'(distance), 6);
      check_value("attack_neg_clip", int'(clip_flag), 1);
      cycle(1'b1, 28'h8000000, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("attack_full_dist", int'(distance), 0);

      // Attack on the last sample of a window
      for (int i = 0; i < 3 * WIN; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      synced = 0;
      for (int i = 0; i < 4 * WIN && !synced; i++) begin
         cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
         if (m_state == 1 && m_cnt == WIN - 2) synced = 1;
      end
      check_value("window_sync", int'(synced), 1);
      cycle(1'b1, 28'h4000000, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("edge_attack_dist", int'(distance), 0);
      check_value("edge_attack_clip", int'(clip_flag), 1);
      check_value("edge_attack_state", int'(state), 2);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("edge_no_release", int'(distance), 0);
      check_value("edge_new_window", int'(state), 1);
      for (int i = 0; i < WIN + 1; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("edge_next_release", int'(distance), 1);

      // Manual override
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b1, 8'd200);
      check_value("manual_clamp", int'(distance), 14);
      check_value("manual_state", int'(state), 3);
      cycle(1'b1, 28'h4000000, 1'b1, 1'b1, 1'b1, 8'd200);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b1, 8'd200);
      check_value("manual_clip", int'(clip_flag), 1);
      check_value("manual_hold", int'(distance), 14);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd200);
      check_value("manual_exit_state", int'(state), 0);
      check_value("manual_exit_dist", int'(distance), 14);

      // Reset mid-window at distance 9
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, 28'h0010000, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("pre_reset_dist", int'(distance), 9);
      for (int i = 0; i < 3; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      cycle(1'b0, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("midreset_dist", int'(distance), 0);
      check_value("midreset_state", int'(state), 0);
      for (int i = 0; i < WIN + 1; i++) cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("postreset_hold", int'(distance), 0);
      cycle(1'b1, QUIET, 1'b1, 1'b1, 1'b0, 8'd0);
      check_value("postreset_release", int'(distance), 1);

      // Randomized traffic
      r_te = 1; r_mm = 0;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 59) == 0) r_te = ~r_te;
         if ($urandom_range(0, 99) == 0) r_mm = ~r_mm;
         r_v  = ($urandom_range(0, 3) != 0);
         r_md = 8'($urandom_range(0, 255));
         r_d  = 28'($urandom);
         if ($urandom_range(0, 3) == 0) r_d = r_d >>> $urandom_range(0, 27);
         else                          r_d = r_d >>> $urandom_range(14, 27);
         cycle(r_rst, r_d, r_v, r_te, r_mm, r_md);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
